moore_seq_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one four-phase Moore sequence engine (P1 → P2/P3 → P4) among up to N_REQ requesters. Each requester asks for one run and supplies a branch bit. The controller grants one requester at a time and steps the engine through its phases, driving the phase code and the Moore output bit. It reports completion with a tagged one-cycle pulse. It sits between requesting client FSMs and the shared sequence output.

---
 rtl/moore_seq_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_moore_seq_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_arbiter.sv
// -----------------------------------------------------------------------------
// moore_seq_arbiter
//
// Purpose:
//   Shares one four-phase Moore sequence engine (P1 -> P2|P3 -> P4) among
//   N_REQ requesters. In IDLE, and in P4 whenever a request is pending, the
//   block picks a winner. It latches that requester's branch bit and steps
//   the engine through its phases. A run always completes once granted; only
//   CLR can abandon it.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest asserted index wins
//                      undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   CLK      in   1      clock, rising edge
//   CLR      in   1      synchronous active-low reset
//   req      in   N_REQ  per-requester run request (level)
//   sel_x1   in   N_REQ  per-requester branch bit, sampled for the winner only
//   grant    out  N_REQ  registered one-hot grant, zero when idle
//   busy     out  1      high in any phase state
//   phase    out  2      00=P1 01=P2 10=P3 11=P4, 00 when idle
//   seq_out  out  1      Moore output of the engine
//   done     out  1      high during P4
//   done_id  out  ID_W   index of the requester being served
//   run_cnt  out  CNT_W  completed-run counter, wraps
// -----------------------------------------------------------------------------
module moore_seq_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] sel_x1,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [1:0]       phase,
    output logic             seq_out,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic [CNT_W-1:0] run_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4
    } state_t;

    state_t           state,      state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [ID_W-1:0]  done_id_nxt;
    logic             x1_lat,     x1_lat_nxt;
    logic [CNT_W-1:0] run_cnt_nxt;
    logic [ID_W-1:0]  win_idx;
    logic             any_req;

`ifndef ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]  rr_ptr,     rr_ptr_nxt;

    // First asserted request at or after ptr, searching upward with wrap.
    // The loop runs from the farthest offset down so the nearest hit wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        int              j;
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (r[j]) pick = ID_W'(j);
        end
        return pick;
    endfunction

    // Pointer moves to one past the winner, modulo N_REQ (N_REQ need not be
    // a power of two, so the wrap is explicit).
    function automatic logic [ID_W-1:0] rr_advance(input logic [ID_W-1:0] w);
        return (int'(w) == N_REQ - 1) ? '0 : w + ID_W'(1);
    endfunction
`else
    function automatic logic [ID_W-1:0] prio_pick(input logic [N_REQ-1:0] r);
        logic [ID_W-1:0] pick;
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) pick = ID_W'(i);
        end
        return pick;
    endfunction
`endif

    assign any_req = |req;

`ifndef ARB_FIXED_PRIO_EN
    assign win_idx = rr_pick(req, rr_ptr);
`else
    assign win_idx = prio_pick(req);
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_nxt   = state;
        grant_nxt   = grant;
        done_id_nxt = done_id;
        x1_lat_nxt  = x1_lat;
        run_cnt_nxt = run_cnt;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_nxt  = rr_ptr;
`endif

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt   = S_P1;
                    grant_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    done_id_nxt = win_idx;
                    x1_lat_nxt  = sel_x1[win_idx];
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_nxt  = rr_advance(win_idx);
`endif
                end
            end
            S_P1:    state_nxt = x1_lat ? S_P2 : S_P3;
            S_P2:    state_nxt = S_P4;
            S_P3:    state_nxt = S_P4;
            S_P4: begin
                run_cnt_nxt = run_cnt + CNT_W'(1);
                if (any_req) begin
                    // Back-to-back hand-over: the new grant replaces the
                    // outgoing one on this same edge, with no idle bubble.
                    state_nxt   = S_P1;
                    grant_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    done_id_nxt = win_idx;
                    x1_lat_nxt  = sel_x1[win_idx];
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_nxt  = rr_advance(win_idx);
`endif
                end else begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and data registers; reset wins over every other event
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!CLR) begin
            state   <= S_IDLE;
            grant   <= '0;
            done_id <= '0;
            x1_lat  <= 1'b0;
            run_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            done_id <= done_id_nxt;
            x1_lat  <= x1_lat_nxt;
            run_cnt <= run_cnt_nxt;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr  <= rr_ptr_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode (state only)
    // -------------------------------------------------------------------------
    always_comb begin
        phase   = 2'b00;
        seq_out = 1'b0;
        case (state)
            S_P1: begin phase = 2'b00; seq_out = 1'b1; end
            S_P2: begin phase = 2'b01; seq_out = 1'b1; end
            S_P3: begin phase = 2'b10; seq_out = 1'b0; end
            S_P4: begin phase = 2'b11; seq_out = 1'b0; end
            default: begin phase = 2'b00; seq_out = 1'b0; end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_P4);

endmodule

// File: tb/tb_moore_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_arbiter
//
// Directed bench for moore_seq_arbiter (N_REQ=4). Inputs change 1 ns after
// a rising edge and outputs are sampled at that same point, well away from
// the next active edge. All expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_moore_seq_arbiter;

    logic       CLK;
    logic       CLR;
    logic [3:0] req;
    logic [3:0] sel_x1;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] phase;
    logic       seq_out;
    logic       done;
    logic [1:0] done_id;
    logic [7:0] run_cnt;

    int n_checks = 0;
    int n_errors = 0;

    moore_seq_arbiter #(
        .N_REQ (4),
        .ID_W  (2),
        .CNT_W (8)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .req     (req),
        .sel_x1  (sel_x1),
        .grant   (grant),
        .busy    (busy),
        .phase   (phase),
        .seq_out (seq_out),
        .done    (done),
        .done_id (done_id),
        .run_cnt (run_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_grant,
                               input logic e_busy, input logic [1:0] e_phase,
                               input logic e_seq, input logic e_done);
        check({tag, ".grant"}, 32'(grant),   32'(e_grant));
        check({tag, ".busy"},  32'(busy),    32'(e_busy));
        check({tag, ".phase"}, 32'(phase),   32'(e_phase));
        check({tag, ".seq"},   32'(seq_out), 32'(e_seq));
        check({tag, ".done"},  32'(done),    32'(e_done));
    endtask

    task automatic do_reset();
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_id;
        logic [1:0] exp_mid;

        CLR    = 1'b0;
        req    = 4'b1111;   // requests during reset must be ignored
        sel_x1 = 4'b0000;
        tick();
        tick();

        // ---------------- reset state ----------------
        check_state("rst", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("rst.done_id", 32'(done_id), 32'd0);
        check("rst.run_cnt", 32'(run_cnt), 32'd0);
        CLR = 1'b1;
        req = 4'b0000;
        tick();
        check_state("idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);

        // ---------------- run 1: req0, branch P2 ----------------
        req    = 4'b0001;
        sel_x1 = 4'b0001;
        tick();
        req = 4'b0000;
        check_state("r1.p1", 4'b0001, 1'b1, 2'b00, 1'b1, 1'b0);
        check("r1.id", 32'(done_id), 32'd0);
        tick();
        check_state("r1.p2", 4'b0001, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        check_state("r1.p4", 4'b0001, 1'b1, 2'b11, 1'b0, 1'b1);
        check("r1.p4.id", 32'(done_id), 32'd0);
        tick();
        check_state("r1.idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("r1.cnt", 32'(run_cnt), 32'd1);

        // ---------------- run 2: req2, branch P3 ----------------
        req    = 4'b0100;
        sel_x1 = 4'b0000;
        tick();
        req = 4'b0000;
        check_state("r2.p1", 4'b0100, 1'b1, 2'b00, 1'b1, 1'b0);
        check("r2.id", 32'(done_id), 32'd2);
        tick();
        check_state("r2.p3", 4'b0100, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        check_state("r2.p4", 4'b0100, 1'b1, 2'b11, 1'b0, 1'b1);
        tick();
        check_state("r2.idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("r2.cnt", 32'(run_cnt), 32'd2);

        // ---------------- all four requesting, back-to-back ----------------
        do_reset();
        req    = 4'b1111;
        sel_x1 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_g  = 4'b0001;
            exp_id = 2'd0;
`else
            exp_g  = 4'b0001 << k;
            exp_id = 2'(k);
`endif
            exp_mid = sel_x1[exp_id] ? 2'b01 : 2'b10;
            tick();
            check_state($sformatf("b2b%0d.p1", k), exp_g, 1'b1, 2'b00, 1'b1, 1'b0);
            check($sformatf("b2b%0d.id", k), 32'(done_id), 32'(exp_id));
            tick();
            check($sformatf("b2b%0d.mid", k), 32'(phase), 32'(exp_mid));
            check($sformatf("b2b%0d.mid.grant", k), 32'(grant), 32'(exp_g));
            tick();
            check_state($sformatf("b2b%0d.p4", k), exp_g, 1'b1, 2'b11, 1'b0, 1'b1);
            check($sformatf("b2b%0d.cnt", k), 32'(run_cnt), 32'(k));
        end
        req = 4'b0000;
        tick();
        check_state("b2b.idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("b2b.cnt", 32'(run_cnt), 32'd4);

        // ---------------- reset in the middle of a run ----------------
        req    = 4'b0010;
        sel_x1 = 4'b0010;
        tick();
        req = 4'b0000;
        check("mr.p1.grant", 32'(grant), 32'h2);
        tick();
        check("mr.p2.phase", 32'(phase), 32'h1);
        CLR = 1'b0;
        tick();
        CLR = 1'b1;
        check_state("mr.rst", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("mr.rst.id", 32'(done_id), 32'd0);
        check("mr.rst.cnt", 32'(run_cnt), 32'd0);
        tick();
        check("mr.nodone", 32'(done), 32'd0);
        // rr_ptr is back at 0, so index 0 beats index 2
        req    = 4'b0101;
        sel_x1 = 4'b0000;
        tick();
        req = 4'b0000;
        check_state("mr.p1", 4'b0001, 1'b1, 2'b00, 1'b1, 1'b0);
        check("mr.id", 32'(done_id), 32'd0);
        tick();
        tick();
        check("mr.p4.done", 32'(done), 32'd1);
        tick();
        check("mr.cnt", 32'(run_cnt), 32'd1);

        // ---------------- one-cycle req pulse, sel change ignored ----------------
        req    = 4'b0010;
        sel_x1 = 4'b0000;
        tick();
        req    = 4'b0000;
        sel_x1 = 4'b1111;
        check_state("pl.p1", 4'b0010, 1'b1, 2'b00, 1'b1, 1'b0);
        tick();
        check_state("pl.p3", 4'b0010, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        check_state("pl.p4", 4'b0010, 1'b1, 2'b11, 1'b0, 1'b1);
        check("pl.id", 32'(done_id), 32'd1);
        tick();
        check_state("pl.idle", 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0);
        check("pl.cnt", 32'(run_cnt), 32'd2);

        // ---------------- run counter wrap ----------------
        do_reset();
        req    = 4'b0001;
        sel_x1 = 4'b0000;
        // 255 complete runs back-to-back, landing in P1 of run 256
        repeat (255 * 3 + 1) tick();
        req = 4'b0000;
        check("wr.p1.phase", 32'(phase), 32'h0);
        check("wr.p1.busy", 32'(busy), 32'h1);
        check("wr.pre", 32'(run_cnt), 32'd255);
        tick();
        tick();
        check("wr.p4.done", 32'(done), 32'd1);
        tick();
        check("wr.wrap", 32'(run_cnt), 32'd0);
        check("wr.idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
